mul_dispatch: RTL and testbench

Upstream issue stage for the team's 32-bit unsigned sequential multiplier (start/finish handshake). Buffers operand pairs from a valid/ready producer in a small FIFO, issues them one at a time to the multiplier, waits for completion, and holds each 64-bit product with its tag in a one-deep result register behind a valid/ready consumer port. Lets producers stream operands without tracking multiplier busy state.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_dispatch_if.sv | 33 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mul_dispatch.sv | 101 ++++++++++
 tb/tb_mul_dispatch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the multiplier dispatch stage and the multiplier bench.
package mul_pkg;
  localparam int MUL_W     = 32;
  localparam int MUL_DEPTH = 4;
  localparam int MUL_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/mul_dispatch_if.sv
// Producer, multiplier and consumer signals of the dispatch stage in one bundle.
interface mul_dispatch_if
  import mul_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int TAG_W = MUL_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_start;
  logic             mul_finish;
  logic [2*W-1:0]   mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  // slave = the dispatch block, master = its surroundings
  modport slave (
    input  in_valid, in_a, in_b, in_tag, mul_finish, mul_p, out_ready,
    output in_ready, mul_a, mul_b, mul_start, out_valid, out_p, out_tag, busy
  );
  modport master (
    output in_valid, in_a, in_b, in_tag, mul_finish, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, mul_start, out_valid, out_p, out_tag, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count; head entry is visible on dout while non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/mul_dispatch.sv
// Queues operand pairs, issues them one at a time to the sequential multiplier and
// parks each product with its tag in a one-deep result register.
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int DEPTH = MUL_DEPTH,
  parameter int TAG_W = MUL_TAG_W
) (
  input logic           clk,
  input logic           rst_n,
  mul_dispatch_if.slave io
);
  localparam int EW = TAG_W + 2*W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push, pop, full, empty;
  logic [EW-1:0] head;
  logic [CW-1:0] count;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [2*W-1:0]   out_p_q, out_p_d;

  assign io.in_ready = (count < CW'(DEPTH));
  assign push        = io.in_valid && !full;

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({io.in_tag, io.in_a, io.in_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Issue only into an empty result slot so a finish never clobbers an unread product.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty && !out_valid_q) begin
        pop     = 1'b1;
        state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (io.mul_finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_tag_d   = out_tag_q;
    if (pop) {tag_d, a_d, b_d} = head;
    if (state_q == WAIT && io.mul_finish) begin
      out_valid_d = 1'b1;
      out_p_d     = io.mul_p;
      out_tag_d   = tag_q;
    end else if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign io.mul_a     = a_q;
  assign io.mul_b     = b_q;
  assign io.mul_start = (state_q == ISSUE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_p     = out_p_q;
  assign io.out_tag   = out_tag_q;
endmodule

// File: tb/tb_mul_dispatch.sv
// Bench for mul_dispatch: directed vector table plus randomized traffic against a queue model.
module tb_mul_dispatch;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] tag; logic [63:0] p; } vec_t;
  typedef struct { logic [31:0] a; logic [31:0] b; } opnd_t;
  typedef struct { logic [63:0] p; logic [3:0] tag; } res_t;

  logic clk, rst_n;
  logic fin_auto, fin_man;
  logic [63:0] p_auto, p_man;
  int n_cmp = 0, n_err = 0, n_starts = 0;
  int mul_lat = 3;
  bit rand_lat = 0;
  opnd_t opnd_q[$];
  res_t  res_q[$];
  bit acc, got;
  logic [63:0] got_p;
  logic [3:0]  got_tag;
  vec_t tbl[5];

  mul_dispatch_if #(.W(32), .TAG_W(4)) ifc ();
  mul_dispatch #(.W(32), .DEPTH(4), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .io(ifc));

  assign ifc.mul_finish = fin_auto | fin_man;
  assign ifc.mul_p      = fin_man ? p_man : p_auto;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Multiplier stand-in: answers each start after a latency with the true product.
  initial begin
    logic [31:0] la, lb;
    opnd_t o;
    int lat;
    fin_auto = 0;
    p_auto   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.mul_start) begin
        n_starts++;
        chk("start_with_result_held", {63'b0, ifc.out_valid}, 64'd0);
        la = ifc.mul_a;
        lb = ifc.mul_b;
        if (opnd_q.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
        else begin
          o = opnd_q.pop_front();
          chk("issue_a", {32'b0, la}, {32'b0, o.a});
          chk("issue_b", {32'b0, lb}, {32'b0, o.b});
        end
        lat = rand_lat ? int'($urandom_range(1, 6)) : mul_lat;
        repeat (lat) @(negedge clk);
        if (ifc.busy) chk("operands_stable", {ifc.mul_a, ifc.mul_b}, {la, lb});
        fin_auto = 1;
        p_auto   = 64'(la) * 64'(lb);
        @(negedge clk);
        fin_auto = 0;
      end
    end
  end

  // One clock: settle, record handshakes into the model, advance to next negedge.
  task automatic cycle();
    res_t r;
    #1;
    acc = ifc.in_valid && ifc.in_ready;
    if (acc) begin
      opnd_q.push_back('{ifc.in_a, ifc.in_b});
      res_q.push_back('{64'(ifc.in_a) * 64'(ifc.in_b), ifc.in_tag});
    end
    got = ifc.out_valid && ifc.out_ready;
    if (got) begin
      got_p   = ifc.out_p;
      got_tag = ifc.out_tag;
      if (res_q.size() == 0) chk("out_unexpected", 64'd1, 64'd0);
      else begin
        r = res_q.pop_front();
        chk("model_out_p", got_p, r.p);
        chk("model_out_tag", {60'b0, got_tag}, {60'b0, r.tag});
      end
    end
    @(negedge clk);
  endtask

  task automatic push_one(logic [31:0] a, logic [31:0] b, logic [3:0] tag, string nm);
    ifc.in_valid = 1; ifc.in_a = a; ifc.in_b = b; ifc.in_tag = tag;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) cycle();
    if (!acc) chk(nm, 64'd0, 64'd1);
    ifc.in_valid = 0;
  endtask

  task automatic wait_out(int maxc, string nm);
    for (int i = 0; i < maxc && !ifc.out_valid; i++) cycle();
    if (!ifc.out_valid) chk(nm, 64'd0, 64'd1);
  endtask

  task automatic drain(int maxc, string nm);
    ifc.out_ready = 1;
    for (int i = 0; i < maxc && (res_q.size() != 0 || ifc.out_valid); i++) cycle();
    chk(nm, 64'(res_q.size()), 64'd0);
    ifc.out_ready = 0;
  endtask

  initial begin
    int s0, k;
    tbl[0] = '{32'd10, 32'd32, 4'd2, 64'h140};
    tbl[1] = '{32'd2, 32'd3, 4'd3, 64'd6};
    tbl[2] = '{32'd0, 32'd7, 4'd4, 64'd0};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 64'hFFFFFFFE00000001};
    tbl[4] = '{32'd1, 32'd1, 4'd6, 64'd1};
    rst_n = 0; fin_man = 0; p_man = '0;
    ifc.in_valid = 0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_tag = '0; ifc.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'b0, ifc.in_ready}, 64'd1);
    chk("rst_mul_start", {63'b0, ifc.mul_start}, 64'd0);
    chk("rst_mul_ab", {ifc.mul_a, ifc.mul_b}, 64'd0);
    chk("rst_out_valid", {63'b0, ifc.out_valid}, 64'd0);
    chk("rst_out_p", ifc.out_p, 64'd0);
    chk("rst_out_tag", {60'b0, ifc.out_tag}, 64'd0);
    chk("rst_busy", {63'b0, ifc.busy}, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // single operation with a long multiplier latency
    mul_lat = 34; s0 = n_starts;
    push_one(32'd351, 32'd23, 4'd1, "single_accept_timeout");
    chk("lat_edge0_start", {63'b0, ifc.mul_start}, 64'd0);
    cycle();
    chk("lat_edge1_start", {63'b0, ifc.mul_start}, 64'd1);
    chk("lat_edge1_ab", {ifc.mul_a, ifc.mul_b}, {32'd351, 32'd23});
    chk("lat_edge1_busy", {63'b0, ifc.busy}, 64'd1);
    cycle();
    chk("lat_edge2_start", {63'b0, ifc.mul_start}, 64'd0);
    chk("lat_edge2_busy", {63'b0, ifc.busy}, 64'd1);
    wait_out(60, "single_timeout");
    chk("single_one_start", 64'(n_starts - s0), 64'd1);
    chk("single_out_p", ifc.out_p, 64'h1F89);
    chk("single_out_tag", {60'b0, ifc.out_tag}, 64'd1);
    ifc.out_ready = 1; cycle(); ifc.out_ready = 0;
    chk("single_cleared", {63'b0, ifc.out_valid}, 64'd0);

    // fill with the consumer stalled
    mul_lat = 3; s0 = n_starts;
    for (int i = 0; i < 5; i++) push_one(tbl[i].a, tbl[i].b, tbl[i].tag, "fill_accept_timeout");
    chk("fill_in_ready_low", {63'b0, ifc.in_ready}, 64'd0);
    repeat (20) cycle();
    chk("fill_one_start", 64'(n_starts - s0), 64'd1);
    chk("fill_result_held", {63'b0, ifc.out_valid}, 64'd1);
    chk("fill_still_full", {63'b0, ifc.in_ready}, 64'd0);

    // drain in push order
    ifc.out_ready = 1; k = 0;
    for (int c = 0; c < 200 && k < 5; c++) begin
      cycle();
      if (got) begin
        chk("drain_p", got_p, tbl[k].p);
        chk("drain_tag", {60'b0, got_tag}, {60'b0, tbl[k].tag});
        k++;
      end
    end
    if (k != 5) chk("drain_timeout", 64'(k), 64'd5);
    ifc.out_ready = 0;
    chk("drain_in_ready", {63'b0, ifc.in_ready}, 64'd1);

    // push in the same cycle as a pop, with two entries queued
    mul_lat = 2;
    push_one(32'd5, 32'd9, 4'd5, "pp_accept_x");
    wait_out(30, "pp_first_timeout");
    push_one(32'd11, 32'd13, 4'd6, "pp_accept_y");
    push_one(32'd17, 32'd19, 4'd7, "pp_accept_z");
    chk("pp_count_before", 64'(dut.u_fifo.count), 64'd2);
    ifc.out_ready = 1; cycle(); ifc.out_ready = 0;
    chk("pp_out_cleared", {63'b0, ifc.out_valid}, 64'd0);
    push_one(32'd23, 32'd29, 4'd8, "pp_accept_w");
    chk("pp_count_after", 64'(dut.u_fifo.count), 64'd2);
    chk("pp_back_to_back_start", {63'b0, ifc.mul_start}, 64'd1);
    drain(200, "pp_drain_left");

    // finish pulse while idle must be ignored
    repeat (3) cycle();
    fin_man = 1; p_man = 64'hDEAD; cycle(); fin_man = 0; cycle();
    chk("spur_out_valid", {63'b0, ifc.out_valid}, 64'd0);
    chk("spur_idle", {63'b0, ifc.busy}, 64'd0);

    // reset while waiting on the multiplier with two entries queued
    mul_lat = 10; ifc.out_ready = 1;
    push_one(32'd3, 32'd4, 4'd9, "rw_accept_0");
    push_one(32'd5, 32'd6, 4'd10, "rw_accept_1");
    push_one(32'd7, 32'd8, 4'd11, "rw_accept_2");
    chk("rw_in_wait", {62'b0, ifc.busy, ifc.mul_start}, 64'd2);
    chk("rw_count", 64'(dut.u_fifo.count), 64'd2);
    #3 rst_n = 0;
    #1;
    chk("rw_busy", {63'b0, ifc.busy}, 64'd0);
    chk("rw_mul_start", {63'b0, ifc.mul_start}, 64'd0);
    chk("rw_mul_ab", {ifc.mul_a, ifc.mul_b}, 64'd0);
    chk("rw_in_ready", {63'b0, ifc.in_ready}, 64'd1);
    chk("rw_out", {ifc.out_valid, ifc.out_tag, ifc.out_p[58:0]}, 64'd0);
    chk("rw_out_p", ifc.out_p, 64'd0);
    chk("rw_count_zero", 64'(dut.u_fifo.count), 64'd0);
    @(negedge clk);
    rst_n = 1;
    opnd_q.delete(); res_q.delete();
    repeat (15) cycle();
    chk("rw_late_finish_ignored", {63'b0, ifc.out_valid}, 64'd0);
    chk("rw_idle_after", {63'b0, ifc.busy}, 64'd0);
    chk("rw_in_ready_after", {63'b0, ifc.in_ready}, 64'd1);
    ifc.out_ready = 0;

    // randomized traffic against the queue model
    rand_lat = 1;
    for (int i = 0; i < 600; i++) begin
      ifc.in_valid  = ($urandom_range(0, 9) < 6);
      ifc.in_a      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      ifc.in_b      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      ifc.in_tag    = 4'($urandom);
      ifc.out_ready = $urandom_range(0, 1) == 1;
      cycle();
    end
    ifc.in_valid = 0;
    drain(400, "rand_drain_left");
    chk("rand_issue_left", 64'(opnd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
